// File: rtl/imem_responder.sv
// Instruction-memory responder: in-order word reads with fixed latency
// (0..4 cycles), a side preload port and an accepted-request counter.
module imem_responder #(
  parameter int p_num_words = 256,
  parameter int p_latency   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  output logic [31:0] imemresp_data,
  output logic        imemresp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] req_count
);

  localparam int AW = $clog2(p_num_words);
  localparam int unsigned LAT = p_latency;

  logic [31:0]   mem [p_num_words];
  logic [31:0]   req_count_q;

  logic [AW-1:0] req_idx;
  logic          req_err;
  logic [31:0]   rd_data;
  logic [AW-1:0] load_idx;
  logic          load_ok;

  // Decode request/load addresses and read the array (pre-write contents).
  always_comb begin
    req_idx  = imemreq_addr[AW+1:2];
    req_err  = (imemreq_addr[1:0] != 2'b00) || (|imemreq_addr[31:AW+2]);
    rd_data  = req_err ? '0 : mem[req_idx];
    load_idx = load_addr[AW+1:2];
    load_ok  = load_en && (load_addr[1:0] == 2'b00) && !(|load_addr[31:AW+2]);
  end

  // Preload write; the array is never reset and ignores loads during reset.
  always_ff @(posedge clk) begin
    if (!rst && load_ok) begin
      mem[load_idx] <= load_data;
    end
  end

  // Count every accepted request, wrapping naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_count_q <= '0;
    end else if (imemreq_val) begin
      req_count_q <= req_count_q + 32'd1;
    end
  end

  assign req_count = req_count_q;

  if (p_latency == 0) begin : g_comb
    // Combinational response in the request cycle; silenced during reset.
    always_comb begin
      imemresp_val  = imemreq_val && !rst;
      imemresp_data = imemresp_val ? rd_data : '0;
      imemresp_err  = imemresp_val && req_err;
    end
  end else begin : g_pipe
    logic [LAT-1:0] pv;
    logic [LAT-1:0] pe;
    logic [31:0]    pd [LAT];

    // Snapshot the read at the accepting edge, then shift LAT-1 more stages.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pv <= '0;
        pe <= '0;
        for (int unsigned i = 0; i < LAT; i++) begin
          pd[i] <= '0;
        end
      end else begin
        pv[0] <= imemreq_val;
        pe[0] <= imemreq_val && req_err;
        pd[0] <= imemreq_val ? rd_data : '0;
        for (int unsigned i = 1; i < LAT; i++) begin
          pv[i] <= pv[i-1];
          pe[i] <= pe[i-1];
          pd[i] <= pd[i-1];
        end
      end
    end

    // Drive the last stage, forcing data/err to zero when not valid.
    always_comb begin
      imemresp_val  = pv[LAT-1];
      imemresp_data = pv[LAT-1] ? pd[LAT-1] : '0;
      imemresp_err  = pv[LAT-1] && pe[LAT-1];
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: five instances (latency 0..4) share one stimulus
// stream and are checked against a per-cycle reference of expected responses.
module tb_imem_responder;

  localparam int NW   = 256;
  localparam int NL   = 5;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        rv [NL];
  logic [31:0] rd [NL];
  logic        re [NL];
  logic [31:0] rc [NL];

  for (genvar g = 0; g < NL; g++) begin : g_dut
    imem_responder #(.p_num_words(NW), .p_latency(g)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .imemreq_val  (imemreq_val),
      .imemreq_addr (imemreq_addr),
      .imemresp_val (rv[g]),
      .imemresp_data(rd[g]),
      .imemresp_err (re[g]),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .req_count    (rc[g])
    );
  end

  always #5 clk = ~clk;

  // Reference state
  logic [31:0] ref_mem [NW];
  logic [31:0] ref_count;
  logic        hv [MAXC];
  logic [31:0] hd [MAXC];
  logic        he [MAXC];
  int          cyc;
  int          valid_from;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'(4 * NW));
  endfunction

  // Check all instances for the current cycle (inputs already applied),
  // then advance one clock and update the reference memory and counter.
  task automatic step();
    int src;
    logic ev;
    logic [31:0] ed;
    logic ee;
    #1;
    hv[cyc] = imemreq_val;
    he[cyc] = imemreq_val && !addr_ok(imemreq_addr);
    hd[cyc] = (imemreq_val && addr_ok(imemreq_addr)) ? ref_mem[imemreq_addr / 4] : 32'h0;
    for (int l = 0; l < NL; l++) begin
      src = cyc - l;
      if (src >= valid_from) begin
        ev = hv[src]; ed = hd[src]; ee = he[src];
      end else begin
        ev = 1'b0; ed = '0; ee = 1'b0;
      end
      chk($sformatf("L%0d val c%0d", l, cyc), {31'b0, rv[l]}, {31'b0, ev});
      chk($sformatf("L%0d data c%0d", l, cyc), rd[l], ed);
      chk($sformatf("L%0d err c%0d", l, cyc), {31'b0, re[l]}, {31'b0, ee});
      chk($sformatf("L%0d count c%0d", l, cyc), rc[l], ref_count);
    end
    @(posedge clk);
    if (imemreq_val) ref_count = ref_count + 32'd1;
    if (load_en && addr_ok(load_addr)) ref_mem[load_addr / 4] = load_data;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic rv_i, input logic [31:0] ra,
                       input logic le_i, input logic [31:0] la, input logic [31:0] ld);
    imemreq_val = rv_i; imemreq_addr = ra;
    load_en = le_i; load_addr = la; load_data = ld;
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return ($urandom_range(0, NW - 1) * 4) + $urandom_range(1, 3);
      1:       return $urandom | 32'h0000_0400;
      2, 3:    return $urandom_range(0, 15) * 4;
      default: return $urandom_range(0, NW - 1) * 4;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    checks = 0; failures = 0; cyc = 0; valid_from = MAXC; ref_count = '0;
    rst = 1'b1;
    imemreq_val = 1'b0; imemreq_addr = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("L%0d reset val", l), {31'b0, rv[l]}, 32'h0);
      chk($sformatf("L%0d reset data", l), rd[l], 32'h0);
      chk($sformatf("L%0d reset count", l), rc[l], 32'h0);
    end
    rst = 1'b0;
    valid_from = cyc;

    // Preload every word with random data
    for (int w = 0; w < NW; w++) drive(1'b0, '0, 1'b1, 32'(w * 4), $urandom);
    drive(1'b0, '0, 1'b1, 32'h0, 32'h0000_0013);
    drive(1'b0, '0, 1'b1, 32'h4, 32'hDEAD_BEEF);
    drive(1'b0, '0, 1'b1, 32'h8, 32'h2222_2222);

    // Back-to-back fetches, then an 8-long burst
    drive(1'b1, 32'h0, 1'b0, '0, '0);
    drive(1'b1, 32'h4, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'(i * 4), 1'b0, '0, '0);
    drive(1'b0, '0, 1'b0, '0, '0);

    // Error requests, then a later read of word 0; ignored out-of-range load
    drive(1'b1, 32'h2, 1'b0, '0, '0);
    drive(1'b1, 32'h400, 1'b1, 32'h400, 32'hBAD0_BAD0);
    drive(1'b1, 32'h0, 1'b1, 32'h1, 32'hBAD1_BAD1);

    // Read-before-write on a same-cycle load and request
    drive(1'b1, 32'h8, 1'b1, 32'h8, 32'h1111_1111);
    drive(1'b1, 32'h8, 1'b0, '0, '0);
    repeat (NL) drive(1'b0, '0, 1'b0, '0, '0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      a = rand_addr();
      drive(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0) ? a : rand_addr(), $urandom);
    end

    // In-flight requests dropped by an asynchronous reset mid-cycle
    drive(1'b1, 32'h0, 1'b0, '0, '0);
    drive(1'b1, 32'h4, 1'b0, '0, '0);
    imemreq_val = 1'b1; imemreq_addr = 32'h8; load_en = 1'b1;
    load_addr = 32'h4; load_data = 32'h5555_5555;
    #2 rst = 1'b1;
    #1;
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("L%0d async rst val", l), {31'b0, rv[l]}, 32'h0);
      chk($sformatf("L%0d async rst data", l), rd[l], 32'h0);
      chk($sformatf("L%0d async rst err", l), {31'b0, re[l]}, 32'h0);
      chk($sformatf("L%0d async rst count", l), rc[l], 32'h0);
    end
    ref_count = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    valid_from = cyc;
    repeat (NL + 1) drive(1'b0, '0, 1'b0, '0, '0);
    drive(1'b1, 32'h4, 1'b0, '0, '0);
    drive(1'b1, 32'h0, 1'b0, '0, '0);
    repeat (NL) drive(1'b0, '0, 1'b0, '0, '0);

    // Counter wrap: preset to 0xFFFFFFFE, two requests bring it to 0
    force g_dut[0].u_dut.req_count_q = 32'hFFFF_FFFE;
    force g_dut[1].u_dut.req_count_q = 32'hFFFF_FFFE;
    force g_dut[2].u_dut.req_count_q = 32'hFFFF_FFFE;
    force g_dut[3].u_dut.req_count_q = 32'hFFFF_FFFE;
    force g_dut[4].u_dut.req_count_q = 32'hFFFF_FFFE;
    #1;
    release g_dut[0].u_dut.req_count_q;
    release g_dut[1].u_dut.req_count_q;
    release g_dut[2].u_dut.req_count_q;
    release g_dut[3].u_dut.req_count_q;
    release g_dut[4].u_dut.req_count_q;
    ref_count = 32'hFFFF_FFFE;
    drive(1'b1, 32'h4, 1'b0, '0, '0);
    drive(1'b1, 32'h0, 1'b0, '0, '0);
    repeat (NL) drive(1'b0, '0, 1'b0, '0, '0);
    for (int l = 0; l < NL; l++) chk($sformatf("L%0d count wrap", l), rc[l], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
